ram_port_arbiter: RTL and testbench

//  Shares one single-port 1-cycle-latency block RAM (data or inst write port) between N_REQ requesters
//  (port 0 = core load/store unit, port 1 = UART program loader). Grants one request per cycle,

---
 rtl/ram_arb_pkg.sv | 19 +
 rtl/ram_arb_pick.sv | 35 +++
 rtl/ram_port_arbiter.sv | 116 +++++++++++
 tb/tb_ram_port_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared types and helpers for the block-RAM port arbiter.
// Default widths, requester-id width helper and the request record type.
package ram_arb_pkg;

    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    // Width of a requester index; never narrower than one bit.
    function automatic int req_id_w(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } ram_req_t;

endpackage

// File: rtl/ram_arb_pick.sv
// Combinational requester pick: first valid bit at or after start_i, wrapping modulo N_REQ.
// Returns the winner as a one-hot vector and as an index.
module ram_arb_pick
    import ram_arb_pkg::*;
#(
    parameter  int N_REQ = 2,
    localparam int ID_W  = req_id_w(N_REQ)
) (
    input  logic [N_REQ-1:0] valid_i,
    input  logic [ID_W-1:0]  start_i,
    output logic [N_REQ-1:0] onehot_o,
    output logic [ID_W-1:0]  id_o,
    output logic             any_o
);

    logic [2*N_REQ-1:0] rot2;

    // NOTE: every output gets a default before the search so no latch is inferred.
    always_comb begin
        onehot_o = '0;
        id_o     = '0;
        any_o    = 1'b0;
        rot2     = {valid_i, valid_i} >> start_i;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_o && rot2[i]) begin
                any_o = 1'b1;
                id_o  = ID_W'((int'(start_i) + i) % N_REQ);
            end
        end
        if (any_o) begin
            onehot_o = N_REQ'(1) << id_o;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one single-port, 1-cycle-latency block RAM between N_REQ requesters with a buffered response.
// Define RAM_ARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ  = 2,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ-1:0]        req_we,
    input  logic [N_REQ*ADDR_W-1:0] req_addr,
    input  logic [N_REQ*DATA_W-1:0] req_wdata,
    output logic [N_REQ-1:0]        rsp_valid,
    input  logic [N_REQ-1:0]        rsp_ready,
    output logic [DATA_W-1:0]       rsp_rdata,
    output logic                    ram_we,
    output logic [ADDR_W-1:0]       ram_addr,
    output logic [DATA_W-1:0]       ram_di,
    input  logic [DATA_W-1:0]       ram_dout
);

    localparam int ID_W = req_id_w(N_REQ);

    logic              pend_valid_q, pend_valid_d;
    logic              hold_valid_q, hold_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;

    logic [ID_W-1:0]   start;
    logic [N_REQ-1:0]  pick_onehot;
    logic [ID_W-1:0]   pick_id;
    logic              pick_any;
    logic              stall;
    logic              grant;

`ifdef RAM_ARB_RR_EN
    logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

    assign start    = rr_ptr_q;
    assign rr_ptr_d = grant ? ID_W'((int'(pick_id) + 1) % N_REQ) : rr_ptr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign start = '0;
`endif

    ram_arb_pick #(.N_REQ(N_REQ)) u_pick (
        .valid_i  (req_valid),
        .start_i  (start),
        .onehot_o (pick_onehot),
        .id_o     (pick_id),
        .any_o    (pick_any)
    );

    // A response still owed to its requester blocks the RAM port; nothing is issued during reset.
    assign stall     = hold_valid_q | (pend_valid_q & ~rsp_ready[rsp_id_q]);
    assign grant     = ~rst & ~stall & pick_any;
    assign req_ready = grant ? pick_onehot : '0;

    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_di   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant && pick_onehot[i]) begin
                ram_we   = req_we[i];
                ram_addr = req_addr[i*ADDR_W +: ADDR_W];
                ram_di   = req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign rsp_valid = (pend_valid_q | hold_valid_q) ? (N_REQ'(1) << rsp_id_q) : '0;
    assign rsp_rdata = hold_valid_q ? hold_data_q : ram_dout;

    always_comb begin
        pend_valid_d = grant;
        rsp_id_d     = grant ? pick_id : rsp_id_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        if (hold_valid_q) begin
            if (rsp_ready[rsp_id_q]) begin
                hold_valid_d = 1'b0;
            end
        end else if (pend_valid_q && !rsp_ready[rsp_id_q]) begin
            hold_valid_d = 1'b1;
            hold_data_d  = ram_dout;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_valid_q <= 1'b0;
            hold_valid_q <= 1'b0;
            rsp_id_q     <= '0;
            hold_data_q  <= '0;
        end else begin
            pend_valid_q <= pend_valid_d;
            hold_valid_q <= hold_valid_d;
            rsp_id_q     <= rsp_id_d;
            hold_data_q  <= hold_data_d;
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomised and directed bench for ram_port_arbiter against a transaction-level reference model.
// Build with RAM_ARB_RR_EN defined to check round-robin arbitration.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int N  = 2;
    localparam int AW = DEF_ADDR_W;
    localparam int DW = DEF_DATA_W;
`ifdef RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid, rsp_ready;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, ram_di, ram_dout;
    logic [AW-1:0]   ram_addr;
    logic            ram_we;

    always #5 clk = ~clk;

    ram_port_arbiter #(.N_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di), .ram_dout(ram_dout)
    );

    // Block RAM: registered output, write-first.
    logic [DW-1:0] ram [1024];
    always @(posedge clk) begin
        if (ram_we) ram[ram_addr] <= ram_di;
        ram_dout <= ram_we ? ram_di : ram[ram_addr];
    end

    // Reference model: memory image plus the single outstanding response.
    logic [DW-1:0] ref_mem [1024];
    bit            m_valid, m_held;
    int            m_id, m_ptr;
    logic [DW-1:0] m_data;

    ram_req_t      cur_req [N];
    bit [N-1:0]    cur_valid;
    logic [N-1:0]  obs_ready, obs_rsp_valid;
    logic [DW-1:0] obs_rdata;
    int            total, bad;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive requests, check against the model, advance the model.
    task automatic step(input logic [N-1:0] rdy);
        int            g, s;
        logic [N-1:0]  e_ready, e_rv;
        logic          e_we;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_di;
        for (int i = 0; i < N; i++) begin
            req_valid[i]            = cur_valid[i];
            req_we[i]               = cur_req[i].we;
            req_addr[i*AW +: AW]    = cur_req[i].addr;
            req_wdata[i*DW +: DW]   = cur_req[i].wdata;
        end
        rsp_ready = rdy;
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
        end
        #1;
        g = -1;
        if (!rst && !(m_valid && (m_held || !rdy[m_id]))) begin
            s = RR ? m_ptr : 0;
            for (int k = 0; k < N; k++)
                if (g < 0 && cur_valid[(s + k) % N]) g = (s + k) % N;
        end
        e_ready = '0; e_we = 1'b0; e_addr = '0; e_di = '0;
        if (g >= 0) begin
            e_ready = N'(1) << g;
            e_we    = cur_req[g].we;
            e_addr  = cur_req[g].addr;
            e_di    = cur_req[g].wdata;
        end
        e_rv = m_valid ? (N'(1) << m_id) : '0;
        obs_ready = req_ready; obs_rsp_valid = rsp_valid; obs_rdata = rsp_rdata;
        check("req_ready", 64'(req_ready), 64'(e_ready));
        check("ram_we", 64'(ram_we), 64'(e_we));
        check("ram_addr", 64'(ram_addr), 64'(e_addr));
        check("ram_di", 64'(ram_di), 64'(e_di));
        check("rsp_valid", 64'(rsp_valid), 64'(e_rv));
        if (m_valid) check("rsp_rdata", 64'(rsp_rdata), 64'(m_data));
        @(posedge clk);
        if (m_valid) begin
            if (rdy[m_id]) m_valid = 1'b0;
            else           m_held  = 1'b1;
        end
        if (g >= 0) begin
            if (cur_req[g].we) begin
                ref_mem[cur_req[g].addr] = cur_req[g].wdata;
                m_data = cur_req[g].wdata;
            end else begin
                m_data = ref_mem[cur_req[g].addr];
            end
            m_valid = 1'b1; m_held = 1'b0; m_id = g;
            m_ptr = (g + 1) % N;
            cur_valid[g] = 1'b0;
        end
        @(negedge clk);
    endtask

    task automatic set_req(input int p, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        cur_req[p].we = we; cur_req[p].addr = a; cur_req[p].wdata = d;
        cur_valid[p] = 1'b1;
    endtask

    logic [N-1:0] exp3 [4];

    initial begin
        total = 0; bad = 0;
        m_valid = 0; m_held = 0; m_id = 0; m_ptr = 0; m_data = '0;
        cur_valid = '0;
        for (int i = 0; i < N; i++) cur_req[i] = '0;
        for (int i = 0; i < 1024; i++) begin
            ram[i] = DW'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        if (RR) begin exp3[0] = 2'b01; exp3[1] = 2'b10; exp3[2] = 2'b01; exp3[3] = 2'b10; end
        else    begin exp3[0] = 2'b01; exp3[1] = 2'b01; exp3[2] = 2'b01; exp3[3] = 2'b01; end

        // Reset with every requester valid.
        rst = 1'b1;
        set_req(0, 1'b0, 10'h001, '0);
        set_req(1, 1'b0, 10'h002, '0);
        @(negedge clk);
        repeat (2) begin
            step(2'b11);
            check("rst_ready", 64'(obs_ready), 64'(0));
            check("rst_rsp_valid", 64'(obs_rsp_valid), 64'(0));
        end
        rst = 1'b0;
        step(2'b11);
        check("post_rst_grant", 64'(obs_ready), 64'(2'b01));
        repeat (3) step(2'b11);

        // Simple read.
        set_req(0, 1'b0, 10'h005, '0);
        step(2'b11);
        check("rd_ready", 64'(obs_ready), 64'(2'b01));
        step(2'b11);
        check("rd_rsp_valid", 64'(obs_rsp_valid), 64'(2'b01));
        check("rd_rdata", 64'(obs_rdata), 64'(32'hDEADBEEF));

        // Write by port 1 then read of the same address by port 0.
        set_req(1, 1'b1, 10'h3FF, 32'h12345678);
        step(2'b11);
        check("wr_ready", 64'(obs_ready), 64'(2'b10));
        set_req(0, 1'b0, 10'h3FF, '0);
        step(2'b11);
        check("wr_rsp_valid", 64'(obs_rsp_valid), 64'(2'b10));
        check("wr_rdata", 64'(obs_rdata), 64'(32'h12345678));
        check("raw_ready", 64'(obs_ready), 64'(2'b01));
        step(2'b11);
        check("raw_rsp_valid", 64'(obs_rsp_valid), 64'(2'b01));
        check("raw_rdata", 64'(obs_rdata), 64'(32'h12345678));

        // Back-pressure on port 0 for three cycles.
        set_req(0, 1'b0, 10'h005, '0);
        step(2'b11);
        set_req(1, 1'b0, 10'h001, '0);
        repeat (3) begin
            step(2'b10);
            check("bp_rsp_valid", 64'(obs_rsp_valid), 64'(2'b01));
            check("bp_rdata", 64'(obs_rdata), 64'(32'hDEADBEEF));
            check("bp_ready", 64'(obs_ready), 64'(0));
        end
        step(2'b11);
        check("bp_accept_ready", 64'(obs_ready), 64'(0));
        step(2'b11);
        check("bp_next_grant", 64'(obs_ready), 64'(2'b10));
        step(2'b11);

        // Reset while a response is held.
        set_req(0, 1'b0, 10'h005, '0);
        step(2'b11);
        step(2'b10);
        step(2'b10);
        rst = 1'b1;
        step(2'b11);
        check("rst_hold_rsp", 64'(obs_rsp_valid), 64'(0));
        rst = 1'b0;
        repeat (2) begin
            step(2'b11);
            check("no_stale_rsp", 64'(obs_rsp_valid), 64'(0));
        end

        // Both ports requesting for four cycles.
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b0, AW'(k), '0);
            set_req(1, 1'b0, AW'(k + 8), '0);
            step(2'b11);
            check("arb_seq", 64'(obs_ready), 64'(exp3[k]));
        end
        repeat (3) step(2'b11);

        // Random traffic.
        for (int c = 0; c < 500; c++) begin
            for (int p = 0; p < N; p++) begin
                if (!cur_valid[p] && ($urandom % 2 == 0)) begin
                    set_req(p, 1'($urandom % 2),
                            ($urandom % 4 == 0) ? 10'h3FF : AW'($urandom % 8),
                            DW'($urandom));
                end
            end
            step({($urandom % 10) < 7, ($urandom % 10) < 7});
        end
        cur_valid = '0;
        repeat (3) step(2'b11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
